gift_dec_keysch_stack: RTL



---
 rtl/gift_dec_keysch_stack.sv | 109 ++++++++++
 1 files changed

// File: rtl/gift_dec_keysch_stack.sv
// GIFT decryption key-schedule working register with a LIFO of saved {key, rc} states.
// All updates land on the rising edge and appear one cycle later; no backpressure, illegal ops raise a sticky error.
module gift_dec_keysch_stack #(
    parameter  int KEY_W = 128,
    parameter  int RC_W  = 6,
    parameter  int DEPTH = 40,
    parameter  int PAD_W = 2,
    localparam int MEM_W = KEY_W + PAD_W + RC_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             inClk,
    input  logic             inRstN,
    input  logic             inExtWr,
    input  logic [KEY_W-1:0] inExtData,
    input  logic             inIntWr,
    input  logic [KEY_W-1:0] inIntData,
    input  logic [RC_W-1:0]  inIntRoundConst,
    input  logic             inPush,
    input  logic             inPop,
    output logic [KEY_W-1:0] outIntData,
    output logic [RC_W-1:0]  outIntRoundConst,
    output logic [MEM_W-1:0] outExtDataToMem,
    output logic [CNT_W-1:0] outCount,
    output logic             outEmpty,
    output logic             outFull,
    output logic             outErr
);

    localparam int ST_W  = KEY_W + RC_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ST_W-1:0]  stack_mem [DEPTH];
    logic [KEY_W-1:0] work_key;
    logic [RC_W-1:0]  work_rc;
    logic [CNT_W-1:0] count;
    logic             err;

    logic             empty;
    logic             full;
    logic             push_req;
    logic             pop_req;
    logic             push_ok;
    logic             pop_ok;
    logic             err_set;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [ST_W-1:0]  pop_entry;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

    // Simultaneous push and pop is treated as a controller bug, not a swap.
    assign push_req = inPush & ~inPop;
    assign pop_req  = inPop & ~inPush;
    assign push_ok  = push_req & ~full;
    assign pop_ok   = pop_req & ~empty;
    assign err_set  = (inPush & inPop) | (push_req & full) | (pop_req & empty);

    assign push_idx  = IDX_W'(count);
    assign pop_idx   = IDX_W'(count - CNT_W'(1));
    assign pop_entry = stack_mem[pop_idx];

    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            work_key <= '0;
            work_rc  <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else if (inExtWr) begin
            work_key <= inExtData;
            work_rc  <= RC_W'(1);
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (pop_ok) begin
                work_key <= pop_entry[ST_W-1:RC_W];
                work_rc  <= pop_entry[RC_W-1:0];
                count    <= count - CNT_W'(1);
            end else begin
                if (inIntWr) begin
                    work_key <= inIntData;
                    work_rc  <= inIntRoundConst;
                end
                if (push_ok) begin
                    count <= count + CNT_W'(1);
                end
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Storage is left unreset: an entry is only ever read after it has been pushed.
    always_ff @(posedge inClk) begin
        if (inRstN && !inExtWr && push_ok) begin
            stack_mem[push_idx] <= {work_key, work_rc};
        end
    end

    assign outIntData       = work_key;
    assign outIntRoundConst = work_rc;
    assign outExtDataToMem  = {work_key, {PAD_W{1'b0}}, work_rc};
    assign outCount         = count;
    assign outEmpty         = empty;
    assign outFull          = full;
    assign outErr           = err;

endmodule
